// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one SDRAM command port between the scanline prefetch reader (port 0)
// and the frame loader/writer (port 1). Issues one-cycle commands, keeps a tag
// FIFO of issued reads and routes in-order read returns back to their issuer.

module sdram_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned BURST_MAX       = 8
) (
    input  logic                                   buffClk,
    input  logic                                   reset,

    input  logic                                   p0_req,
    input  logic                                   p0_we,
    input  logic [23:0]                            p0_addr,
    input  logic [15:0]                            p0_wdata,
    input  logic                                   p0_urgent,
    output logic                                   p0_gnt,
    output logic                                   p0_rvalid,
    output logic [15:0]                            p0_rdata,

    input  logic                                   p1_req,
    input  logic                                   p1_we,
    input  logic [23:0]                            p1_addr,
    input  logic [15:0]                            p1_wdata,
    output logic                                   p1_gnt,
    output logic                                   p1_rvalid,
    output logic [15:0]                            p1_rdata,

    input  logic                                   busy,
    output logic [23:0]                            address,
    output logic                                   write,
    output logic [15:0]                            dataOut,
    output logic                                   read,
    input  logic [15:0]                            dataIn,
    input  logic                                   readReady,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   orphan_err
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned BW = $clog2(BURST_MAX + 1);

    localparam logic [OW-1:0] FULL_COUNT = OW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_SLOT  = PW'(MAX_OUTSTANDING - 1);
    localparam logic [BW-1:0] BURST_LIM  = BW'(BURST_MAX);

    typedef enum logic {
        ARB   = 1'b0,
        ISSUE = 1'b1
    } stateT;

    stateT          state;
    stateT          stateNext;

    logic           winPort;
    logic           winWe;
    logic           lastGnt;
    logic [BW-1:0]  burstCnt;

    logic           tagMem [MAX_OUTSTANDING];
    logic [PW-1:0]  rdPtr;
    logic [PW-1:0]  wrPtr;
    logic [OW-1:0]  tagCount;

    logic           fifoFull;
    logic           fifoEmpty;
    logic           elig0;
    logic           elig1;
    logic           grant;
    logic           grantPort;
    logic           push;
    logic           pop;
    logic           headId;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // Eligibility and winner selection among the requesting ports.
    always_comb begin
        fifoFull  = (tagCount == FULL_COUNT);
        fifoEmpty = (tagCount == '0);
        elig0     = p0_req & (p0_we | ~fifoFull);
        elig1     = p1_req & (p1_we | ~fifoFull);
        grantPort = 1'b0;
        if (p0_urgent & elig0) begin
            grantPort = 1'b0;
        end else if (elig0 & ~elig1) begin
            grantPort = 1'b0;
        end else if (elig1 & ~elig0) begin
            grantPort = 1'b1;
        end else if (burstCnt == BURST_LIM) begin
            // An exhausted burst hands over to the other port; with both
            // eligible this coincides with the round-robin choice below.
            grantPort = ~lastGnt;
        end else begin
            grantPort = ~lastGnt;
        end
    end

    // Next-state and command strobes: ARB picks a winner, ISSUE lasts one cycle.
    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        write     = 1'b0;
        read      = 1'b0;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        push      = 1'b0;
        case (state)
            ARB: begin
                if (~busy & (elig0 | elig1)) begin
                    grant     = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                write     = winWe;
                read      = ~winWe;
                p0_gnt    = ~winPort;
                p1_gnt    = winPort;
                push      = ~winWe;
                stateNext = ARB;
            end
            default: stateNext = ARB;
        endcase
    end

    // State register.
    always_ff @(posedge buffClk) begin
        if (reset) begin
            state <= ARB;
        end else begin
            state <= stateNext;
        end
    end

    // Latch the winner's command when it is granted; held until the next grant.
    always_ff @(posedge buffClk) begin
        if (reset) begin
            winPort <= 1'b0;
            winWe   <= 1'b0;
            address <= '0;
            dataOut <= '0;
        end else if (grant) begin
            winPort <= grantPort;
            winWe   <= grantPort ? p1_we    : p0_we;
            address <= grantPort ? p1_addr  : p0_addr;
            dataOut <= grantPort ? p1_wdata : p0_wdata;
        end
    end

    // Last-granted port and saturating burst count.
    always_ff @(posedge buffClk) begin
        if (reset) begin
            lastGnt  <= 1'b1;
            burstCnt <= '0;
        end else if (grant) begin
            lastGnt <= grantPort;
            if (grantPort == lastGnt) begin
                if (burstCnt != BURST_LIM) begin
                    burstCnt <= burstCnt + 1'b1;
                end
            end else begin
                burstCnt <= BW'(1);
            end
        end else if (lastGnt ? ~p0_req : ~p1_req) begin
            burstCnt <= '0;
        end
    end

    assign pop    = readReady & ~fifoEmpty;
    assign headId = tagMem[rdPtr];

    // Return-tag FIFO: push on read issue, pop on read return, both may coincide.
    always_ff @(posedge buffClk) begin
        if (reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            tagCount <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                tagMem[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                tagMem[wrPtr] <= winPort;
                wrPtr         <= ptrInc(wrPtr);
            end
            if (pop) begin
                rdPtr <= ptrInc(rdPtr);
            end
            case ({push, pop})
                2'b10:   tagCount <= tagCount + 1'b1;
                2'b01:   tagCount <= tagCount - 1'b1;
                default: tagCount <= tagCount;
            endcase
        end
    end

    assign outstanding = tagCount;

    // Registered return routing to the issuing port; sticky orphan flag.
    always_ff @(posedge buffClk) begin
        if (reset) begin
            p0_rvalid  <= 1'b0;
            p1_rvalid  <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            orphan_err <= 1'b0;
        end else begin
            p0_rvalid <= pop & ~headId;
            p1_rvalid <= pop & headId;
            if (pop & ~headId) begin
                p0_rdata <= dataIn;
            end
            if (pop & headId) begin
                p1_rdata <= dataIn;
            end
            if (readReady & fifoEmpty) begin
                orphan_err <= 1'b1;
            end
        end
    end

endmodule
